// File: rtl/wav_dfi_proto_checker_if.sv
// DFI signal bundle watched by wav_dfi_proto_checker.
// The master modport drives the bundle; the slave modport (the checker) only samples it.
interface wav_dfi_proto_checker_if #(
    parameter int NUM_PHASES = 4,
    parameter int ADDR_W     = 14
);
    logic                         lp_ctrl_req;
    logic                         lp_ctrl_ack;
    logic                         lp_data_req;
    logic                         lp_data_ack;
    logic                         ctrlupd_req;
    logic                         ctrlupd_ack;
    logic                         phyupd_req;
    logic                         phyupd_ack;
    logic                         phymstr_ack;
    logic                         init_start;
    logic [NUM_PHASES*ADDR_W-1:0] address;
    logic [NUM_PHASES-1:0]        wrdata_en;
    logic [NUM_PHASES-1:0]        rddata_en;

    modport master (
        output lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack,
        output ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack, phymstr_ack, init_start,
        output address, wrdata_en, rddata_en
    );

    modport slave (
        input lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack,
        input ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack, phymstr_ack, init_start,
        input address, wrdata_en, rddata_en
    );
endinterface

// File: rtl/wav_dfi_proto_checker.sv
// DFI protocol checker: handshake FSMs, combinational rule checks, sticky flags and a saturating error count.
// Define WAV_DFI_CHK_FIRST_ERR_EN to add first-error capture (id and cycle stamp).
module wav_dfi_proto_checker #(
    parameter int NUM_PHASES   = 4,
    parameter int ADDR_W       = 14,
    parameter int TLP_RESP     = 8,
    parameter int TPHYUPD_RESP = 16,
    parameter int CNT_W        = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   chk_en,
    input  logic                   err_clr,
    wav_dfi_proto_checker_if.slave dfi,
    output logic [9:0]             err_flags,
    output logic [9:0]             err_event,
    output logic [CNT_W-1:0]       err_count
`ifdef WAV_DFI_CHK_FIRST_ERR_EN
    ,
    output logic                   first_err_vld,
    output logic [3:0]             first_err_id,
    output logic [31:0]            first_err_cycle
`endif
);
    localparam int NCH = 3;  // channel 0: lp_ctrl, 1: lp_data, 2: phyupd
    localparam logic [7:0] LP_LIM = 8'(TLP_RESP);
    localparam logic [7:0] PU_LIM = 8'(TPHYUPD_RESP);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACKED} ch_state_e;

    typedef struct packed {
        logic                         en;
        logic                         lpc_req;
        logic                         lpc_ack;
        logic                         lpd_req;
        logic                         lpd_ack;
        logic                         cupd_req;
        logic                         cupd_ack;
        logic                         pupd_req;
        logic                         pupd_ack;
        logic                         pmstr_ack;
        logic                         init;
        logic [NUM_PHASES*ADDR_W-1:0] addr;
        logic [NUM_PHASES-1:0]        wren;
        logic [NUM_PHASES-1:0]        rden;
    } smp_t;

    smp_t             smp_d, smp_q;
    logic             prev_pu_req_d, prev_pu_req_q;
    logic             live_d, live_q;
    ch_state_e        st_d  [NCH];
    ch_state_e        st_q  [NCH];
    logic [7:0]       cnt_d [NCH];
    logic [7:0]       cnt_q [NCH];
    logic [NCH-1:0]   done_d, done_q, blk_d, blk_q;
    logic [NCH-1:0]   ch_req, ch_ack, ack_noreq, tmo;
    logic             addr_nz, pu_stuck, cupd_noreq, forbidden, bus_busy, lp_traffic;
    logic [9:0]       viol, err_event_d, err_event_q, err_flags_d, err_flags_q;
    logic [CNT_W-1:0] err_count_d, err_count_q;

    always_comb begin
        smp_d           = '0;
        smp_d.en        = chk_en;
        smp_d.lpc_req   = dfi.lp_ctrl_req;
        smp_d.lpc_ack   = dfi.lp_ctrl_ack;
        smp_d.lpd_req   = dfi.lp_data_req;
        smp_d.lpd_ack   = dfi.lp_data_ack;
        smp_d.cupd_req  = dfi.ctrlupd_req;
        smp_d.cupd_ack  = dfi.ctrlupd_ack;
        smp_d.pupd_req  = dfi.phyupd_req;
        smp_d.pupd_ack  = dfi.phyupd_ack;
        smp_d.pmstr_ack = dfi.phymstr_ack;
        smp_d.init      = dfi.init_start;
        smp_d.addr      = dfi.address;
        smp_d.wren      = dfi.wrdata_en;
        smp_d.rden      = dfi.rddata_en;
        prev_pu_req_d   = smp_q.pupd_req;
        live_d          = 1'b1;
    end

    assign ch_req = {smp_q.pupd_req, smp_q.lpd_req, smp_q.lpc_req};
    assign ch_ack = {smp_q.pupd_ack, smp_q.lpd_ack, smp_q.lpc_ack};

    // After reset a channel stays blocked until it has been seen fully idle, so a
    // handshake that was already in flight across reset is never reported.
    always_comb begin
        ack_noreq = '0;
        tmo       = '0;
        done_d    = done_q;
        blk_d     = blk_q;
        for (int c = 0; c < NCH; c++) begin
            st_d[c]  = st_q[c];
            cnt_d[c] = cnt_q[c];
            if (!smp_q.en || blk_q[c]) begin
                st_d[c]   = ST_IDLE;
                cnt_d[c]  = '0;
                done_d[c] = 1'b0;
                if (smp_q.en && live_q && !ch_req[c] && !ch_ack[c])
                    blk_d[c] = 1'b0;
            end else begin
                case (st_q[c])
                    ST_IDLE: begin
                        done_d[c]    = 1'b0;
                        cnt_d[c]     = '0;
                        ack_noreq[c] = ch_ack[c];
                        if (ch_req[c] && !ch_ack[c]) begin
                            st_d[c]  = ST_WAIT;
                            cnt_d[c] = 8'd1;
                        end else if (ch_req[c] && ch_ack[c]) begin
                            st_d[c] = ST_ACKED;
                        end
                    end
                    ST_WAIT: begin
                        if (ch_ack[c]) begin
                            st_d[c] = ST_ACKED;
                        end else if (!ch_req[c]) begin
                            st_d[c] = ST_IDLE;
                        end else begin
                            if (cnt_q[c] == ((c == NCH-1) ? PU_LIM : LP_LIM)) begin
                                tmo[c]    = ~done_q[c];
                                done_d[c] = 1'b1;
                            end else begin
                                cnt_d[c] = cnt_q[c] + 8'd1;
                            end
                        end
                    end
                    ST_ACKED: begin
                        if (!ch_ack[c]) begin
                            ack_noreq[c] = ch_req[c];
                            st_d[c]      = ST_IDLE;
                        end
                    end
                    default: st_d[c] = ST_IDLE;
                endcase
            end
        end
    end

    // An ack during init is as illegal as the matching request, so init_start pairs with both ctrlupd signals.
    always_comb begin
        addr_nz    = |smp_q.addr;
        pu_stuck   = smp_q.en & ~blk_q[2] & smp_q.pupd_ack & ~prev_pu_req_q;
        cupd_noreq = smp_q.cupd_ack & ~smp_q.cupd_req;
        forbidden  = (smp_q.pupd_ack & smp_q.pmstr_ack) |
                     (smp_q.init & (smp_q.pupd_ack | smp_q.pmstr_ack | smp_q.cupd_req |
                                    smp_q.cupd_ack | smp_q.lpc_req | smp_q.lpd_req));
        bus_busy   = (smp_q.pupd_ack | smp_q.cupd_ack) & (addr_nz | smp_q.lpc_req | smp_q.lpd_req);
        lp_traffic = (smp_q.lpd_req & ((|smp_q.wren) | (|smp_q.rden))) | (smp_q.lpc_req & addr_nz);
        viol = {lp_traffic, bus_busy, forbidden, pu_stuck, tmo[2],
                cupd_noreq, tmo[1], ack_noreq[1], tmo[0], ack_noreq[0]};
        err_event_d = smp_q.en ? viol : '0;
    end

    // Clear is applied before this cycle's event, so a coincident event survives the clear.
    always_comb begin
        err_flags_d = (err_clr ? '0 : err_flags_q) | err_event_q;
        err_count_d = err_clr ? '0 : err_count_q;
        if ((|err_event_q) && (err_count_d != {CNT_W{1'b1}}))
            err_count_d = err_count_d + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            smp_q         <= '0;
            prev_pu_req_q <= 1'b0;
            live_q        <= 1'b0;
            done_q        <= '0;
            blk_q         <= '1;
            for (int c = 0; c < NCH; c++) begin
                st_q[c]  <= ST_IDLE;
                cnt_q[c] <= '0;
            end
            err_event_q <= '0;
            err_flags_q <= '0;
            err_count_q <= '0;
        end else begin
            smp_q         <= smp_d;
            prev_pu_req_q <= prev_pu_req_d;
            live_q        <= live_d;
            done_q        <= done_d;
            blk_q         <= blk_d;
            for (int c = 0; c < NCH; c++) begin
                st_q[c]  <= st_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            err_event_q <= err_event_d;
            err_flags_q <= err_flags_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_event = err_event_q;
    assign err_flags = err_flags_q;
    assign err_count = err_count_q;

`ifdef WAV_DFI_CHK_FIRST_ERR_EN
    function automatic logic [3:0] lowest_bit(input logic [9:0] v);
        lowest_bit = '0;
        for (int i = 9; i >= 0; i--)
            if (v[i]) lowest_bit = 4'(i);
    endfunction

    logic [31:0] cyc_d, cyc_q, fe_cyc_d, fe_cyc_q;
    logic        fe_vld_d, fe_vld_q;
    logic [3:0]  fe_id_d, fe_id_q;

    always_comb begin
        cyc_d    = cyc_q + 32'd1;
        fe_vld_d = err_clr ? 1'b0 : fe_vld_q;
        fe_id_d  = err_clr ? '0 : fe_id_q;
        fe_cyc_d = err_clr ? '0 : fe_cyc_q;
        if ((|err_event_q) && !fe_vld_d) begin
            fe_vld_d = 1'b1;
            fe_id_d  = lowest_bit(err_event_q);
            fe_cyc_d = cyc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q    <= '0;
            fe_vld_q <= 1'b0;
            fe_id_q  <= '0;
            fe_cyc_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            fe_vld_q <= fe_vld_d;
            fe_id_q  <= fe_id_d;
            fe_cyc_q <= fe_cyc_d;
        end
    end

    assign first_err_vld   = fe_vld_q;
    assign first_err_id    = fe_id_q;
    assign first_err_cycle = fe_cyc_q;
`endif
endmodule

// File: tb/tb_wav_dfi_proto_checker.sv
// Directed bench for wav_dfi_proto_checker: handshake timeouts, rule checks, clear/saturation and reset behaviour.
// First-error outputs are checked only when WAV_DFI_CHK_FIRST_ERR_EN is defined.
module tb_wav_dfi_proto_checker;
    localparam int NUM_PHASES = 4;
    localparam int ADDR_W     = 14;
    localparam int CNT_W      = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             chk_en;
    logic             err_clr;
    logic [9:0]       err_flags;
    logic [9:0]       err_event;
    logic [CNT_W-1:0] err_count;
`ifdef WAV_DFI_CHK_FIRST_ERR_EN
    logic             first_err_vld;
    logic [3:0]       first_err_id;
    logic [31:0]      first_err_cycle;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    logic [9:0] ev_or;
    int         ev_cyc;

    wav_dfi_proto_checker_if #(.NUM_PHASES(NUM_PHASES), .ADDR_W(ADDR_W)) dfi ();

    wav_dfi_proto_checker dut (
        .clock          (clock),
        .reset          (reset),
        .chk_en         (chk_en),
        .err_clr        (err_clr),
        .dfi            (dfi),
        .err_flags      (err_flags),
        .err_event      (err_event),
        .err_count      (err_count)
`ifdef WAV_DFI_CHK_FIRST_ERR_EN
        ,
        .first_err_vld  (first_err_vld),
        .first_err_id   (first_err_id),
        .first_err_cycle(first_err_cycle)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog expired before the directed sequence finished");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic step_acc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            ev_or = ev_or | err_event;
            if (err_event != 10'h0) ev_cyc++;
        end
    endtask

    task automatic clr_acc();
        ev_or  = '0;
        ev_cyc = 0;
    endtask

    task automatic idle_bus();
        dfi.lp_ctrl_req = 1'b0;
        dfi.lp_ctrl_ack = 1'b0;
        dfi.lp_data_req = 1'b0;
        dfi.lp_data_ack = 1'b0;
        dfi.ctrlupd_req = 1'b0;
        dfi.ctrlupd_ack = 1'b0;
        dfi.phyupd_req  = 1'b0;
        dfi.phyupd_ack  = 1'b0;
        dfi.phymstr_ack = 1'b0;
        dfi.init_start  = 1'b0;
        dfi.address     = '0;
        dfi.wrdata_en   = '0;
        dfi.rddata_en   = '0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        chk_en  = 1'b1;
        err_clr = 1'b0;
        idle_bus();
        clr_acc();
        step(3);
        chk_val("rst_flags", 32'(err_flags), 32'h0);
        chk_val("rst_event", 32'(err_event), 32'h0);
        chk_val("rst_count", 32'(err_count), 32'h0);
        reset = 1'b0;
        step(3);

        // lp_ctrl request unanswered for 9 samples: one timeout
        clr_acc();
        dfi.lp_ctrl_req = 1'b1;
        step_acc(9);
        dfi.lp_ctrl_req = 1'b0;
        step_acc(4);
        chk_val("lpc_tmo_event", 32'(ev_or), 32'h002);
        chk_val("lpc_tmo_pulses", 32'(ev_cyc), 32'd1);
        chk_val("lpc_tmo_flags", 32'(err_flags), 32'h002);
        chk_val("lpc_tmo_count", 32'(err_count), 32'd1);
        pulse_clr();
        chk_val("clr_flags", 32'(err_flags), 32'h0);
        chk_val("clr_count", 32'(err_count), 32'h0);

        // lp_ctrl ack with no request
        clr_acc();
        dfi.lp_ctrl_ack = 1'b1;
        step_acc(1);
        dfi.lp_ctrl_ack = 1'b0;
        step_acc(3);
        chk_val("lpc_noreq_event", 32'(ev_or), 32'h001);
        chk_val("lpc_noreq_count", 32'(err_count), 32'd1);
        pulse_clr();

        // lp_data request held only 8 samples: just under the limit
        clr_acc();
        dfi.lp_data_req = 1'b1;
        step_acc(8);
        dfi.lp_data_req = 1'b0;
        step_acc(4);
        chk_val("lpd_8cyc_event", 32'(ev_or), 32'h0);

        // clean lp_data handshake
        clr_acc();
        dfi.lp_data_req = 1'b1;
        step_acc(2);
        dfi.lp_data_ack = 1'b1;
        step_acc(1);
        dfi.lp_data_req = 1'b0;
        step_acc(1);
        dfi.lp_data_ack = 1'b0;
        step_acc(4);
        chk_val("lpd_ok_event", 32'(ev_or), 32'h0);
        chk_val("lpd_ok_count", 32'(err_count), 32'h0);

        // phyupd timeout, then ack left high after req drops
        clr_acc();
        dfi.phyupd_req = 1'b1;
        step_acc(17);
        dfi.phyupd_ack = 1'b1;
        step_acc(1);
        dfi.phyupd_req = 1'b0;
        step_acc(1);
        step_acc(1);
        dfi.phyupd_ack = 1'b0;
        step_acc(4);
        chk_val("pupd_event", 32'(ev_or), 32'h060);
        chk_val("pupd_pulses", 32'(ev_cyc), 32'd2);
        chk_val("pupd_flags", 32'(err_flags), 32'h060);
        chk_val("pupd_count", 32'(err_count), 32'd2);
        pulse_clr();

        // ctrlupd_ack with address and init_start in one cycle
        dfi.ctrlupd_ack = 1'b1;
        dfi.init_start  = 1'b1;
        dfi.address[2*ADDR_W +: ADDR_W] = 14'h0001;
        step(1);
        idle_bus();
        step(1);
        chk_val("multi_event", 32'(err_event), 32'h190);
        step(1);
        chk_val("multi_event_end", 32'(err_event), 32'h0);
        chk_val("multi_flags", 32'(err_flags), 32'h190);
        chk_val("multi_count", 32'(err_count), 32'd1);
`ifdef WAV_DFI_CHK_FIRST_ERR_EN
        chk_val("first_vld", 32'(first_err_vld), 32'd1);
        chk_val("first_id", 32'(first_err_id), 32'd4);
`endif

        // err_clr coincident with an LP_TRAFFIC event
        dfi.lp_data_req = 1'b1;
        dfi.wrdata_en   = 4'b0010;
        step(1);
        idle_bus();
        step(1);
        chk_val("lptraf_event", 32'(err_event), 32'h200);
        pulse_clr();
        chk_val("clr_evt_flags", 32'(err_flags), 32'h200);
        chk_val("clr_evt_count", 32'(err_count), 32'd1);
`ifdef WAV_DFI_CHK_FIRST_ERR_EN
        chk_val("first_id_after_clr", 32'(first_err_id), 32'd9);
`endif

        // checks disabled: no events, sticky state kept
        clr_acc();
        chk_en = 1'b0;
        dfi.ctrlupd_ack = 1'b1;
        step_acc(4);
        idle_bus();
        step_acc(2);
        chk_en = 1'b1;
        step_acc(3);
        chk_val("dis_event", 32'(ev_or), 32'h0);
        chk_val("dis_flags", 32'(err_flags), 32'h200);
        chk_val("dis_count", 32'(err_count), 32'd1);

        // counter saturation under a continuous violation
        pulse_clr();
        dfi.ctrlupd_ack = 1'b1;
        step(65536);
        chk_val("sat_fffe", 32'(err_count), 32'hFFFE);
        step(1);
        chk_val("sat_ffff", 32'(err_count), 32'hFFFF);
        step(5);
        chk_val("sat_hold", 32'(err_count), 32'hFFFF);
        idle_bus();
        step(3);
        dfi.lp_data_ack = 1'b1;
        step(1);
        dfi.lp_data_ack = 1'b0;
        step(4);
        chk_val("sat_more", 32'(err_count), 32'hFFFF);

        // reset while lp_ctrl and phyupd are mid-WAIT
        dfi.lp_ctrl_req = 1'b1;
        dfi.phyupd_req  = 1'b1;
        step(5);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk_val("rst2_flags", 32'(err_flags), 32'h0);
        chk_val("rst2_count", 32'(err_count), 32'h0);
        clr_acc();
        step_acc(20);
        idle_bus();
        step_acc(4);
        chk_val("rst2_event", 32'(ev_or), 32'h0);
        chk_val("rst2_count_end", 32'(err_count), 32'h0);

        // checker is live again once the bus went idle
        clr_acc();
        dfi.lp_ctrl_ack = 1'b1;
        step_acc(1);
        dfi.lp_ctrl_ack = 1'b0;
        step_acc(3);
        chk_val("rearm_event", 32'(ev_or), 32'h001);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
